victim_writeback_buffer: RTL and testbench
==========================================

// Module: victim_writeback_buffer
// PURPOSE
//  Accepts 512-bit blocks evicted by the victim cache (its block_out) with their {ptag,vindex}
//  line address and queues them in a small FIFO. Drains each queued block to the memory side as
//  eight 64-bit beats under a valid/ready handshake. Offers a snoop port so a victim-cache miss
//  can detect a line still pending writeback. Sits between victim cache and next memory level.
// PARAMETERS
//  DEPTH    4    FIFO entries (power of 2, >=2)
//  ADDR_W   50   line address width, {ptag[43:0], vindex[5:0]}
//  BLOCK_W  512  block width
//  BEAT_W   64   memory beat width; BEATS = BLOCK_W/BEAT_W = 8
// PORTS
//  clk          in   1                 clock, all state on rising edge
//  reset        in   1                 asynchronous, active-low (0 = in reset)
//  evict_valid  in   1                 eviction block offered this cycle
//  evict_addr   in   ADDR_W            line address of offered block
//  evict_block  in   BLOCK_W           offered block data
//  evict_ready  out  1                 buffer can accept (count < DEPTH)
//  mem_valid    out  1                 beat presented to memory
//  mem_addr     out  ADDR_W            line address of head block
//  mem_beat     out  3                 beat index 0..7
//  mem_data     out  BEAT_W            head block bits [mem_beat*64 +: 64]
//  mem_last     out  1                 mem_valid && mem_beat==7
//  mem_ready    in   1                 memory accepts current beat
//  lookup_addr  in   ADDR_W            snoop address
//  lookup_hit   out  1                 lookup_addr matches any occupied entry
//  count        out  $clog2(DEPTH)+1   occupied entries
// BEHAVIOUR
//  - Reset (reset==0, async): wr/rd ptr=0, count=0, beat=0, state=IDLE. Outputs: evict_ready=1,
//    mem_valid=0, mem_last=0, mem_beat=0, mem_addr=0, mem_data=0, lookup_hit=0, count=0.
//    Storage array not reset. Reset mid-transfer drops all queued blocks; mem_valid falls at once.
//  - Enqueue: evict_valid && evict_ready at edge -> write {addr,block} at wr_ptr, wr_ptr++ (wraps
//    mod DEPTH). evict_ready depends only on count, never on same-cycle drain: full => 0.
//    evict_valid while !evict_ready is ignored (no state change).
//  - Pop: the accepted beat 7 frees head entry, rd_ptr++ (wraps).
//  - Enqueue and pop same edge: count unchanged. Otherwise count +1 / -1.
//  - FSM IDLE: mem_valid=0; if count!=0 -> SEND, beat=0 (first beat one cycle after enqueue).
//  - FSM SEND: mem_valid=1. Beat accept (mem_valid&&mem_ready): beat<7 -> beat++;
//    beat==7 -> pop, beat=0; stay SEND if count after pop !=0 (back-to-back, no bubble),
//    else IDLE.
//  - Stall rule: while mem_valid && !mem_ready, mem_addr/mem_beat/mem_data held stable and
//    mem_valid stays 1. Beats of a block strictly in order 0..7, blocks strictly FIFO.
//  - mem_addr/mem_data forced to 0 whenever mem_valid=0.
//  - lookup_hit: combinational OR of (entry occupied && addr==lookup_addr) over all entries,
//    including head being drained until its beat 7 is accepted. Same-edge enqueue visible next
//    cycle. Duplicate addresses allowed; each written back in order.
//  - Arithmetic: ptrs $clog2(DEPTH) bits wrap naturally; count saturates by construction (0..DEPTH).
// TESTING
//  1. Enqueue addr=0x123, block byte k = k, mem_ready=1 -> SEND next cycle; beats 0..7 on
//     consecutive cycles, beat0 data=0x0706050403020100, mem_last only on beat7, count 1->0.
//  2. Same block, mem_ready = 1,0,1,0... -> each beat held stable while stalled; 8 beats
//     over 16 cycles; data order unchanged.
//  3. mem_ready=0, enqueue A,B,C,D -> count=4, evict_ready=0; 5th evict_valid ignored;
//     mem_ready=1 -> 32 back-to-back beats A,B,C,D, no bubble, then IDLE, evict_ready=1.
//  4. Queue X=0x2AB, lookup_addr=X -> lookup_hit=1 through beat 7 cycle; 0 the cycle after
//     beat 7 accepted; lookup of unqueued addr -> 0.
//  5. count=2, evict_valid on same edge as beat-7 accept -> count stays 2, new block
//     drained after remaining one.
//  6. reset=0 during beat 3 of block with count=3 -> mem_valid=0 immediately, count=0,
//     evict_ready=1; after release, no beats issued until new enqueue.

Source files
------------

// File: rtl/victim_writeback_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : victim_writeback_buffer
//  Purpose  : Small FIFO between the victim cache and the next memory level.
//             Accepts evicted 512-bit blocks with their {ptag,vindex} line
//             address, drains each block as eight 64-bit beats under a
//             valid/ready handshake, and offers a snoop port so a victim
//             cache miss can find a line still waiting to be written back.
//  Ports    : clk                     - clock, all state on rising edge
//             reset                   - asynchronous, active-low
//             evict_valid/addr/block  - eviction offer from victim cache
//             evict_ready             - buffer has a free entry
//             mem_valid/addr/beat/data/last, mem_ready - memory beat channel
//             lookup_addr, lookup_hit - snoop of occupied entries
//             count                   - occupied entries (0..DEPTH)
//  Revision : 1.0 - initial release
// ============================================================================
module victim_writeback_buffer #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 50,
    parameter int BLOCK_W = 512,
    parameter int BEAT_W  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   evict_valid,
    input  logic [ADDR_W-1:0]      evict_addr,
    input  logic [BLOCK_W-1:0]     evict_block,
    output logic                   evict_ready,
    output logic                   mem_valid,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [2:0]             mem_beat,
    output logic [BEAT_W-1:0]      mem_data,
    output logic                   mem_last,
    input  logic                   mem_ready,
    input  logic [ADDR_W-1:0]      lookup_addr,
    output logic                   lookup_hit,
    output logic [$clog2(DEPTH):0] count
);

    localparam int         c_PTR_W     = $clog2(DEPTH);
    localparam int         c_CNT_W     = c_PTR_W + 1;
    localparam int         c_BEATS     = BLOCK_W / BEAT_W;
    localparam logic [2:0] c_LAST_BEAT = 3'(c_BEATS - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SEND = 1'b1;

    logic [ADDR_W-1:0]  r_addr_mem [DEPTH];
    logic [BLOCK_W-1:0] r_data_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [2:0]         r_beat;
    logic [0:0]         r_state;

    logic               w_push;
    logic               w_accept;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_count_next;
    logic [BLOCK_W-1:0] w_head_block;
    logic [BEAT_W-1:0]  w_head_beat;
    logic [DEPTH-1:0]   w_hit_vec;

    // Ready depends only on occupancy, so a full buffer refuses a block even
    // when the head is being popped on the same edge.
    assign evict_ready = (r_count < c_CNT_W'(DEPTH));
    assign w_push      = evict_valid && evict_ready;
    assign mem_valid   = (r_state == c_ST_SEND);
    assign w_accept    = mem_valid && mem_ready;
    assign w_pop       = w_accept && (r_beat == c_LAST_BEAT);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_CNT_W'(1);
        end
    end

    // Storage is intentionally not reset; occupancy is derived from pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_wr_ptr] <= evict_addr;
            r_data_mem[r_wr_ptr] <= evict_block;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_beat   <= '0;
            r_state  <= c_ST_IDLE;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= w_count_next;

            case (r_state)
                c_ST_IDLE: begin
                    if (r_count != '0) begin
                        r_state <= c_ST_SEND;
                        r_beat  <= '0;
                    end
                end
                c_ST_SEND: begin
                    if (w_accept) begin
                        if (r_beat == c_LAST_BEAT) begin
                            r_beat <= '0;
                            // Continue straight into the next block (including
                            // one enqueued on this very edge) without a bubble.
                            r_state <= (w_count_next != '0) ? c_ST_SEND : c_ST_IDLE;
                        end else begin
                            r_beat <= r_beat + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_beat  <= '0;
                end
            endcase
        end
    end

    assign w_head_block = r_data_mem[r_rd_ptr];

    always_comb begin
        w_head_beat = '0;
        for (int b = 0; b < c_BEATS; b++) begin
            if (r_beat == 3'(b)) begin
                w_head_beat = w_head_block[b*BEAT_W +: BEAT_W];
            end
        end
    end

    assign mem_addr = mem_valid ? r_addr_mem[r_rd_ptr] : '0;
    assign mem_data = mem_valid ? w_head_beat : '0;
    assign mem_beat = r_beat;
    assign mem_last = mem_valid && (r_beat == c_LAST_BEAT);
    assign count    = r_count;

    // An entry is occupied when its distance from the read pointer is below
    // the count; the head stays visible until its last beat is accepted.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_hit
            logic [c_PTR_W-1:0] w_offset;
            assign w_offset     = c_PTR_W'(i) - r_rd_ptr;
            assign w_hit_vec[i] = ({1'b0, w_offset} < r_count) &&
                                  (r_addr_mem[i] == lookup_addr);
        end
    endgenerate

    assign lookup_hit = |w_hit_vec;

endmodule
`default_nettype wire

// File: tb/tb_victim_writeback_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_victim_writeback_buffer
//  Purpose  : Directed self-checking bench for victim_writeback_buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_victim_writeback_buffer;

    localparam int ADDR_W  = 50;
    localparam int BLOCK_W = 512;
    localparam int BEAT_W  = 64;

    logic               clk = 1'b0;
    logic               reset;
    logic               evict_valid;
    logic [ADDR_W-1:0]  evict_addr;
    logic [BLOCK_W-1:0] evict_block;
    logic               evict_ready;
    logic               mem_valid;
    logic [ADDR_W-1:0]  mem_addr;
    logic [2:0]         mem_beat;
    logic [BEAT_W-1:0]  mem_data;
    logic               mem_last;
    logic               mem_ready;
    logic [ADDR_W-1:0]  lookup_addr;
    logic               lookup_hit;
    logic [2:0]         count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    victim_writeback_buffer #(
        .DEPTH  (4),
        .ADDR_W (ADDR_W),
        .BLOCK_W(BLOCK_W),
        .BEAT_W (BEAT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .evict_valid(evict_valid),
        .evict_addr (evict_addr),
        .evict_block(evict_block),
        .evict_ready(evict_ready),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_beat   (mem_beat),
        .mem_data   (mem_data),
        .mem_last   (mem_last),
        .mem_ready  (mem_ready),
        .lookup_addr(lookup_addr),
        .lookup_hit (lookup_hit),
        .count      (count)
    );

    // Block whose byte k equals base+k (mod 256).
    function automatic logic [BLOCK_W-1:0] mk_block(input logic [7:0] base);
        logic [BLOCK_W-1:0] r;
        for (int k = 0; k < BLOCK_W/8; k++) r[k*8 +: 8] = base + 8'(k);
        return r;
    endfunction

    // Expected beat b of a mk_block(base) block: bytes 8b..8b+7.
    function automatic logic [BEAT_W-1:0] exp_beat(input logic [7:0] base, input int b);
        logic [BEAT_W-1:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = base + 8'(b*8 + k);
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b0; evict_valid = 1'b0; evict_addr = '0; evict_block = '0;
        mem_ready = 1'b0; lookup_addr = '0;
        repeat (2) @(negedge clk);
        checks++; if (evict_ready !== 1'b1) begin failures++; $display("FAIL reset_evict_ready act=%b req=1", evict_ready); end
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid act=%b req=0", mem_valid); end
        checks++; if (mem_last !== 1'b0) begin failures++; $display("FAIL reset_mem_last act=%b req=0", mem_last); end
        checks++; if (mem_beat !== 3'd0) begin failures++; $display("FAIL reset_mem_beat act=%0d req=0", mem_beat); end
        checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr act=%h req=0", mem_addr); end
        checks++; if (mem_data !== '0) begin failures++; $display("FAIL reset_mem_data act=%h req=0", mem_data); end
        checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL reset_lookup_hit act=%b req=0", lookup_hit); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count act=%0d req=0", count); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        @(negedge clk);
        evict_valid = 1'b1; evict_addr = 50'h123; evict_block = mk_block(8'h00); mem_ready = 1'b1;
        @(negedge clk);
        evict_valid = 1'b0;
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count_after_enq act=%0d req=1", count); end
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL single_idle_cycle act=%b req=0", mem_valid); end
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL single_valid b=%0d act=%b req=1", b, mem_valid); end
            checks++; if (mem_beat !== 3'(b)) begin failures++; $display("FAIL single_beat act=%0d req=%0d", mem_beat, b); end
            checks++; if (mem_addr !== 50'h123) begin failures++; $display("FAIL single_addr b=%0d act=%h req=123", b, mem_addr); end
            checks++; if (mem_data !== exp_beat(8'h00, b)) begin failures++; $display("FAIL single_data b=%0d act=%h req=%h", b, mem_data, exp_beat(8'h00, b)); end
            checks++; if (mem_last !== (b == 7)) begin failures++; $display("FAIL single_last b=%0d act=%b req=%b", b, mem_last, (b == 7)); end
            if (b == 0) begin
                checks++; if (mem_data !== 64'h0706050403020100) begin failures++; $display("FAIL single_beat0_const act=%h req=0706050403020100", mem_data); end
            end
            if (b == 7) begin
                checks++; if (mem_data !== 64'h3F3E3D3C3B3A3938) begin failures++; $display("FAIL single_beat7_const act=%h req=3f3e3d3c3b3a3938", mem_data); end
            end
        end
        @(negedge clk);
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL single_done_valid act=%b req=0", mem_valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_done_count act=%0d req=0", count); end
        checks++; if (mem_data !== '0) begin failures++; $display("FAIL single_done_data act=%h req=0", mem_data); end
    endtask

    task automatic test_stall();
        @(negedge clk);
        evict_valid = 1'b1; evict_addr = 50'h123; evict_block = mk_block(8'h00);
        @(negedge clk);
        evict_valid = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL stall_valid i=%0d act=%b req=1", i, mem_valid); end
            checks++; if (mem_beat !== 3'(i/2)) begin failures++; $display("FAIL stall_beat i=%0d act=%0d req=%0d", i, mem_beat, i/2); end
            checks++; if (mem_data !== exp_beat(8'h00, i/2)) begin failures++; $display("FAIL stall_data i=%0d act=%h req=%h", i, mem_data, exp_beat(8'h00, i/2)); end
            mem_ready = (i % 2 == 1);
        end
        @(negedge clk);
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL stall_done_valid act=%b req=0", mem_valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL stall_done_count act=%0d req=0", count); end
    endtask

    task automatic test_fill();
        logic [ADDR_W-1:0] addrs [4];
        logic [7:0]        bases [4];
        addrs[0] = 50'h0A0; addrs[1] = 50'h0B1; addrs[2] = 50'h0C2; addrs[3] = 50'h0D3;
        bases[0] = 8'h10;   bases[1] = 8'h50;   bases[2] = 8'h90;   bases[3] = 8'hD0;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            evict_valid = 1'b1; evict_addr = addrs[i]; evict_block = mk_block(bases[i]);
        end
        @(negedge clk);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count act=%0d req=4", count); end
        checks++; if (evict_ready !== 1'b0) begin failures++; $display("FAIL fill_ready act=%b req=0", evict_ready); end
        evict_addr = 50'h3FF; evict_block = mk_block(8'hEE);
        @(negedge clk);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_ignored_count act=%0d req=4", count); end
        checks++; if (mem_addr !== addrs[0]) begin failures++; $display("FAIL fill_head_addr act=%h req=%h", mem_addr, addrs[0]); end
        evict_valid = 1'b0; mem_ready = 1'b1;
        for (int j = 0; j < 32; j++) begin
            if (j > 0) @(negedge clk);
            checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL fill_valid j=%0d act=%b req=1", j, mem_valid); end
            checks++; if (mem_addr !== addrs[j/8]) begin failures++; $display("FAIL fill_addr j=%0d act=%h req=%h", j, mem_addr, addrs[j/8]); end
            checks++; if (mem_beat !== 3'(j%8)) begin failures++; $display("FAIL fill_beat j=%0d act=%0d req=%0d", j, mem_beat, j%8); end
            checks++; if (mem_data !== exp_beat(bases[j/8], j%8)) begin failures++; $display("FAIL fill_data j=%0d act=%h req=%h", j, mem_data, exp_beat(bases[j/8], j%8)); end
            checks++; if (count !== 3'(4 - j/8)) begin failures++; $display("FAIL fill_drain_count j=%0d act=%0d req=%0d", j, count, 4 - j/8); end
        end
        @(negedge clk);
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL fill_done_valid act=%b req=0", mem_valid); end
        checks++; if (evict_ready !== 1'b1) begin failures++; $display("FAIL fill_done_ready act=%b req=1", evict_ready); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL fill_done_count act=%0d req=0", count); end
    endtask

    task automatic test_lookup();
        @(negedge clk);
        evict_valid = 1'b1; evict_addr = 50'h2AB; evict_block = mk_block(8'h40);
        mem_ready = 1'b1; lookup_addr = 50'h2AB;
        #1;
        checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL lookup_before_enq act=%b req=0", lookup_hit); end
        @(negedge clk);
        evict_valid = 1'b0;
        checks++; if (lookup_hit !== 1'b1) begin failures++; $display("FAIL lookup_after_enq act=%b req=1", lookup_hit); end
        lookup_addr = 50'h2AC;
        #1;
        checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL lookup_other_addr act=%b req=0", lookup_hit); end
        lookup_addr = 50'h2AB;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            checks++; if (mem_beat !== 3'(b)) begin failures++; $display("FAIL lookup_beat act=%0d req=%0d", mem_beat, b); end
            checks++; if (lookup_hit !== 1'b1) begin failures++; $display("FAIL lookup_during_drain b=%0d act=%b req=1", b, lookup_hit); end
        end
        @(negedge clk);
        checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL lookup_after_pop act=%b req=0", lookup_hit); end
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL lookup_done_valid act=%b req=0", mem_valid); end
    endtask

    task automatic test_same_edge();
        logic [ADDR_W-1:0] addrs [3];
        logic [7:0]        bases [3];
        addrs[0] = 50'h301; addrs[1] = 50'h302; addrs[2] = 50'h303;
        bases[0] = 8'h20;   bases[1] = 8'hA0;   bases[2] = 8'h60;
        mem_ready = 1'b0;
        @(negedge clk);
        evict_valid = 1'b1; evict_addr = addrs[0]; evict_block = mk_block(bases[0]);
        @(negedge clk);
        evict_addr = addrs[1]; evict_block = mk_block(bases[1]);
        @(negedge clk);
        evict_valid = 1'b0;
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL same_start_count act=%0d req=2", count); end
        mem_ready = 1'b1;
        for (int j = 0; j < 24; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 8) evict_valid = 1'b0;
            checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL same_valid j=%0d act=%b req=1", j, mem_valid); end
            checks++; if (mem_addr !== addrs[j/8]) begin failures++; $display("FAIL same_addr j=%0d act=%h req=%h", j, mem_addr, addrs[j/8]); end
            checks++; if (mem_beat !== 3'(j%8)) begin failures++; $display("FAIL same_beat j=%0d act=%0d req=%0d", j, mem_beat, j%8); end
            checks++; if (mem_data !== exp_beat(bases[j/8], j%8)) begin failures++; $display("FAIL same_data j=%0d act=%h req=%h", j, mem_data, exp_beat(bases[j/8], j%8)); end
            checks++; if (count !== ((j < 16) ? 3'd2 : 3'd1)) begin failures++; $display("FAIL same_count j=%0d act=%0d req=%0d", j, count, (j < 16) ? 2 : 1); end
            if (j == 7) begin
                evict_valid = 1'b1; evict_addr = addrs[2]; evict_block = mk_block(bases[2]);
            end
        end
        @(negedge clk);
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL same_done_valid act=%b req=0", mem_valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL same_done_count act=%0d req=0", count); end
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            evict_valid = 1'b1; evict_addr = 50'h500 + 50'(i); evict_block = mk_block(8'(i * 16));
        end
        @(negedge clk);
        evict_valid = 1'b0;
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL rmid_count act=%0d req=3", count); end
        mem_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge clk);
            checks++; if (mem_beat !== 3'(b)) begin failures++; $display("FAIL rmid_beat act=%0d req=%0d", mem_beat, b); end
        end
        reset = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid_drop act=%b req=0", mem_valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rmid_count_clear act=%0d req=0", count); end
        checks++; if (evict_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready act=%b req=1", evict_ready); end
        checks++; if (mem_data !== '0) begin failures++; $display("FAIL rmid_data act=%h req=0", mem_data); end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_beats act=%b req=0", mem_valid); end
        end
        evict_valid = 1'b1; evict_addr = 50'h777; evict_block = mk_block(8'h33);
        @(negedge clk);
        evict_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_addr !== 50'h777) begin failures++; $display("FAIL rmid_new_addr act=%h req=777", mem_addr); end
        checks++; if (mem_data !== exp_beat(8'h33, 0)) begin failures++; $display("FAIL rmid_new_data act=%h req=%h", mem_data, exp_beat(8'h33, 0)); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL rmid_new_count act=%0d req=1", count); end
        repeat (8) @(negedge clk);
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rmid_final_count act=%0d req=0", count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_fill();
        test_lookup();
        test_same_edge();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
